apb_ahb3lite_bridge: RTL and testbench



---
 rtl/apb_ahb3lite_bridge_if.sv | 43 ++++
 rtl/apb_ahb3lite_bridge.sv | 143 ++++++++++++++
 tb/tb_apb_ahb3lite_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_ahb3lite_bridge_if.sv
// Bus bundle for the APB4-responder / AHB3-Lite-initiator bridge.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface apb_ahb3lite_bridge_if #(
  parameter int HADDR_SIZE = 32,
  parameter int PADDR_SIZE = 16
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [PADDR_SIZE-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  logic [HADDR_SIZE-1:0] HADDR;
  logic [31:0]           HWDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic [31:0]           HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR,
    output HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR,
    input  HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/apb_ahb3lite_bridge.sv
// APB4 responder that turns each APB access into one AHB3-Lite single transfer.
// Write strobes select HSIZE and the low address bits; unsupported strobe patterns complete on APB only.
module apb_ahb3lite_bridge #(
  parameter int                    HADDR_SIZE = 32,
  parameter int                    PADDR_SIZE = 16,
  parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_ahb3lite_bridge_if.slave bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HWORD   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  // Keeps only the HADDR_BASE bits above the APB address range.
  localparam logic [HADDR_SIZE-1:0] BASE_MASK =
    ~((HADDR_SIZE'(1) << PADDR_SIZE) - HADDR_SIZE'(1));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           prdata_reg;
  logic                  pready_reg;
  logic                  pslverr_reg;
  logic [HADDR_SIZE-1:0] haddr_reg;
  logic [31:0]           hwdata_reg;
  logic                  hwrite_reg;
  logic [2:0]            hsize_reg;
  logic [3:0]            hprot_reg;
  logic [1:0]            htrans_reg;

  logic                  strb_legal;
  logic [2:0]            strb_size;
  logic [1:0]            strb_off;
  logic [2:0]            setup_size;
  logic [1:0]            setup_off;
  logic [HADDR_SIZE-1:0] setup_addr;

  always_comb begin
    strb_legal = 1'b1;
    strb_size  = HSIZE_WORD;
    strb_off   = 2'b00;
    case (bus.PSTRB)
      4'b0001: begin strb_size = HSIZE_BYTE;  strb_off = 2'd0; end
      4'b0010: begin strb_size = HSIZE_BYTE;  strb_off = 2'd1; end
      4'b0100: begin strb_size = HSIZE_BYTE;  strb_off = 2'd2; end
      4'b1000: begin strb_size = HSIZE_BYTE;  strb_off = 2'd3; end
      4'b0011: begin strb_size = HSIZE_HWORD; strb_off = 2'd0; end
      4'b1100: begin strb_size = HSIZE_HWORD; strb_off = 2'd2; end
      4'b1111: begin strb_size = HSIZE_WORD;  strb_off = 2'd0; end
      default: strb_legal = 1'b0;
    endcase
  end

  assign setup_size = bus.PWRITE ? strb_size : HSIZE_WORD;
  assign setup_off  = bus.PWRITE ? strb_off  : 2'b00;
  assign setup_addr = (HADDR_BASE & BASE_MASK)
                    | HADDR_SIZE'({bus.PADDR[PADDR_SIZE-1:2], setup_off});

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      wdata_reg   <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      haddr_reg   <= '0;
      hwdata_reg  <= '0;
      hwrite_reg  <= 1'b0;
      hsize_reg   <= 3'b000;
      hprot_reg   <= 4'b0000;
      htrans_reg  <= HTRANS_IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
          prdata_reg  <= '0;
          if (bus.PSEL && !bus.PENABLE) begin
            wdata_reg <= bus.PWDATA;
            if (!bus.PWRITE || strb_legal) begin
              haddr_reg  <= setup_addr;
              hwrite_reg <= bus.PWRITE;
              hsize_reg  <= setup_size;
              hprot_reg  <= {2'b00, bus.PPROT[0], ~bus.PPROT[2]};
              htrans_reg <= HTRANS_NONSEQ;
              state_reg  <= ADDR;
            end else begin
              // An all-zero strobe is a harmless no-op; any other unsupported pattern is an error.
              pready_reg  <= 1'b1;
              pslverr_reg <= (bus.PSTRB != 4'b0000);
              state_reg   <= RESP;
            end
          end
        end
        ADDR: begin
          if (bus.HREADY) begin
            htrans_reg <= HTRANS_IDLE;
            hwdata_reg <= hwrite_reg ? wdata_reg : 32'h0;
            state_reg  <= DATA;
          end
        end
        DATA: begin
          // HRESP during the HREADY=0 half of a two-cycle error is ignored.
          if (bus.HREADY) begin
            prdata_reg  <= hwrite_reg ? 32'h0 : bus.HRDATA;
            pslverr_reg <= bus.HRESP;
            pready_reg  <= 1'b1;
            hwdata_reg  <= '0;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
          prdata_reg  <= '0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.PPROT[1], bus.PADDR[1:0]};

  assign bus.PRDATA    = prdata_reg;
  assign bus.PREADY    = pready_reg;
  assign bus.PSLVERR   = pslverr_reg;
  assign bus.HADDR     = haddr_reg;
  assign bus.HWDATA    = hwdata_reg;
  assign bus.HWRITE    = hwrite_reg;
  assign bus.HSIZE     = hsize_reg;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = hprot_reg;
  assign bus.HTRANS    = htrans_reg;
  assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_apb_ahb3lite_bridge.sv
// Directed bench for apb_ahb3lite_bridge: a per-access model predicts every output cycle by cycle,
// and literal values from hand-worked scenarios pin the model.
module tb_apb_ahb3lite_bridge;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_ahb3lite_bridge_if #(.HADDR_SIZE(32), .PADDR_SIZE(16)) bus ();

  apb_ahb3lite_bridge #(
    .HADDR_SIZE(32),
    .PADDR_SIZE(16),
    .HADDR_BASE(BASE)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected behaviour of the access currently in flight.
  logic        m_wr, m_legal, m_err;
  logic [2:0]  m_size;
  logic [1:0]  m_off;
  logic [31:0] m_haddr, m_wdata, m_prdata;
  logic [3:0]  m_hprot;
  int          m_aw, m_dw, m_lat;
  int          cyc;
  bit          active = 1'b0;

  // What the DUT actually showed, for the literal checks.
  int          seen_rdy;
  logic [31:0] seen_prdata, seen_haddr1, seen_hwdata2;
  logic        seen_err, seen_hwrite1, any_trans;
  logic [2:0]  seen_hsize1;

  always @(negedge PCLK) begin
    if (active) begin
      chk("hburst", 32'(bus.HBURST), 32'h0);
      chk("hmastlock", 32'(bus.HMASTLOCK), 32'h0);
      chk("pready", 32'(bus.PREADY), 32'(cyc == m_lat));
      if (cyc == m_lat) begin
        chk("prdata", bus.PRDATA, m_prdata);
        chk("pslverr", 32'(bus.PSLVERR), 32'(m_err));
      end else begin
        chk("prdata_quiet", bus.PRDATA, 32'h0);
        chk("pslverr_quiet", 32'(bus.PSLVERR), 32'h0);
      end
      if (m_legal && cyc >= 1 && cyc <= m_aw + 1) begin
        chk("htrans_nonseq", 32'(bus.HTRANS), 32'h2);
        chk("haddr", bus.HADDR, m_haddr);
        chk("hsize", 32'(bus.HSIZE), 32'(m_size));
        chk("hwrite", 32'(bus.HWRITE), 32'(m_wr));
        chk("hprot", 32'(bus.HPROT), 32'(m_hprot));
      end else begin
        chk("htrans_idle", 32'(bus.HTRANS), 32'h0);
      end
      if (m_legal && m_wr && cyc >= m_aw + 2 && cyc <= m_aw + 2 + m_dw)
        chk("hwdata", bus.HWDATA, m_wdata);

      if (bus.PREADY && seen_rdy < 0) begin
        seen_rdy    = cyc;
        seen_prdata = bus.PRDATA;
        seen_err    = bus.PSLVERR;
      end
      if (cyc == 1) begin
        seen_haddr1  = bus.HADDR;
        seen_hsize1  = bus.HSIZE;
        seen_hwrite1 = bus.HWRITE;
      end
      if (cyc == 2) seen_hwdata2 = bus.HWDATA;
      if (bus.HTRANS != 2'b00) any_trans = 1'b1;
    end
  end

  task automatic access(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int aw, input int dw,
                        input logic rsp_err, input logic [31:0] rdata);
    int pop, off;
    logic [3:0] mask;
    pop = $countones(strb);
    off = 0;
    for (int i = 3; i >= 0; i--) if (strb[i]) off = i;
    mask = 4'(((1 << pop) - 1) << off);
    m_wr = wr;
    if (!wr) begin
      m_legal = 1'b1; m_size = 3'd2; m_off = 2'd0;
    end else begin
      m_legal = 1'b0;
      if (pop == 1 || pop == 2 || pop == 4)
        m_legal = (strb == mask) && (off % pop == 0);
      m_size = (pop == 4) ? 3'd2 : (pop == 2) ? 3'd1 : 3'd0;
      m_off  = 2'(off);
    end
    m_err    = (wr && !m_legal) ? (strb != 4'b0000) : rsp_err;
    m_aw     = aw;
    m_dw     = dw;
    m_lat    = m_legal ? aw + dw + 3 : 1;
    m_wdata  = wdata;
    m_prdata = wr ? 32'h0 : rdata;
    m_haddr  = (BASE & 32'hFFFF_0000) | ({16'h0, addr} & 32'h0000_FFFC) | {30'h0, m_off};
    m_hprot  = {2'b00, prot[0], ~prot[2]};
    seen_rdy = -1; seen_prdata = '0; seen_err = 1'b0; any_trans = 1'b0;
    seen_haddr1 = '0; seen_hsize1 = '0; seen_hwrite1 = 1'b0; seen_hwdata2 = '0;

    for (int c = 0; c <= m_lat; c++) begin
      @(posedge PCLK); #1;
      cyc = c;
      active = 1'b1;
      bus.PSEL = 1'b1;
      bus.PENABLE = (c != 0);
      bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata; bus.PSTRB = strb; bus.PPROT = prot;
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = 32'hBAD0_0000 ^ 32'(c);
      if (m_legal) begin
        if ((c >= 1 && c <= aw) || (c >= aw + 2 && c <= aw + 1 + dw)) bus.HREADY = 1'b0;
        if (rsp_err && c >= aw + 2 && (c == aw + 1 + dw || c == aw + 2 + dw)) bus.HRESP = 1'b1;
        if (c == aw + 2 + dw) bus.HRDATA = rdata;
      end
    end
    @(negedge PCLK); #1;
    active = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    $display("txn %s addr=0x%04h strb=%b aw=%0d dw=%0d pready_at=T%0d prdata=0x%08h pslverr=%0b",
             wr ? "WR" : "RD", addr, strb, aw, dw, seen_rdy, seen_prdata, seen_err);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pready"}, 32'(bus.PREADY), 32'h0);
    chk({tag, "_pslverr"}, 32'(bus.PSLVERR), 32'h0);
    chk({tag, "_prdata"}, bus.PRDATA, 32'h0);
    chk({tag, "_htrans"}, 32'(bus.HTRANS), 32'h0);
    chk({tag, "_haddr"}, bus.HADDR, 32'h0);
    chk({tag, "_hwdata"}, bus.HWDATA, 32'h0);
    chk({tag, "_hwrite"}, 32'(bus.HWRITE), 32'h0);
    chk({tag, "_hsize"}, 32'(bus.HSIZE), 32'h0);
    chk({tag, "_hprot"}, 32'(bus.HPROT), 32'h0);
    chk({tag, "_hburst"}, 32'(bus.HBURST), 32'h0);
    chk({tag, "_hmastlock"}, 32'(bus.HMASTLOCK), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0;
    bus.PWDATA = '0; bus.PSTRB = '0; bus.PPROT = '0;
    bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk_reset_values("rst");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Minimum read.
    access(1'b0, 16'h0104, 32'h0, 4'b0000, 3'b000, 0, 0, 1'b0, 32'hDEAD_BEEF);
    chk("rd_haddr_lit", seen_haddr1, 32'h4000_0104);
    chk("rd_hsize_lit", 32'(seen_hsize1), 32'h2);
    chk("rd_rdy_lit", 32'(seen_rdy), 32'd3);
    chk("rd_prdata_lit", seen_prdata, 32'hDEAD_BEEF);

    // Upper-halfword write.
    access(1'b1, 16'h0020, 32'h1234_5678, 4'b1100, 3'b010, 0, 0, 1'b0, 32'h0);
    chk("wr_haddr_lit", seen_haddr1, 32'h4000_0022);
    chk("wr_hsize_lit", 32'(seen_hsize1), 32'h1);
    chk("wr_hwrite_lit", 32'(seen_hwrite1), 32'h1);
    chk("wr_hwdata_lit", seen_hwdata2, 32'h1234_5678);
    chk("wr_rdy_lit", 32'(seen_rdy), 32'd3);

    // Illegal strobe: APB-only completion with error.
    access(1'b1, 16'h0030, 32'hFFFF_0000, 4'b0101, 3'b000, 0, 0, 1'b0, 32'h0);
    chk("ill_rdy_lit", 32'(seen_rdy), 32'd1);
    chk("ill_err_lit", 32'(seen_err), 32'h1);
    chk("ill_notrans_lit", 32'(any_trans), 32'h0);

    // Zero strobe: APB-only completion without error.
    access(1'b1, 16'h0034, 32'h0000_0001, 4'b0000, 3'b000, 0, 0, 1'b0, 32'h0);
    chk("zero_rdy_lit", 32'(seen_rdy), 32'd1);
    chk("zero_err_lit", 32'(seen_err), 32'h0);

    // Read with wait states in both phases.
    access(1'b0, 16'h0008, 32'h0, 4'b0000, 3'b001, 2, 3, 1'b0, 32'hCAFE_F00D);
    chk("stall_rdy_lit", 32'(seen_rdy), 32'd8);
    chk("stall_prdata_lit", seen_prdata, 32'hCAFE_F00D);

    // Byte write to lane 3 with privileged instruction protection.
    access(1'b1, 16'h00F0, 32'hA5A5_1234, 4'b1000, 3'b101, 0, 0, 1'b0, 32'h0);
    chk("byte_haddr_lit", seen_haddr1, 32'h4000_00F3);
    chk("byte_hsize_lit", 32'(seen_hsize1), 32'h0);

    // Two-cycle AHB error then a back-to-back clean read.
    access(1'b1, 16'h0044, 32'h5555_AAAA, 4'b1111, 3'b000, 0, 2, 1'b1, 32'h0);
    chk("err_pslverr_lit", 32'(seen_err), 32'h1);
    access(1'b0, 16'h0048, 32'h0, 4'b0000, 3'b000, 0, 0, 1'b0, 32'h0BAD_F00D);
    chk("after_err_pslverr_lit", 32'(seen_err), 32'h0);
    chk("after_err_prdata_lit", seen_prdata, 32'h0BAD_F00D);

    access(1'b1, 16'h0050, 32'h0, 4'b0110, 3'b000, 0, 0, 1'b0, 32'h0);
    access(1'b1, 16'h0012, 32'h0000_BEEF, 4'b0011, 3'b000, 1, 0, 1'b0, 32'h0);
    chk("lowhw_haddr_lit", seen_haddr1, 32'h4000_0010);

    // Reset while the AHB data phase is stalled.
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 16'h0200; bus.HREADY = 1'b1;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus.HREADY = 1'b0;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.HREADY = 1'b1;
    @(negedge PCLK);
    chk_reset_values("midrst");
    @(negedge PCLK);
    chk("midrst_pready_after", 32'(bus.PREADY), 32'h0);
    chk("midrst_htrans_after", 32'(bus.HTRANS), 32'h0);
    $display("txn RST during data phase htrans=%0d pready=%0b", bus.HTRANS, bus.PREADY);

    access(1'b0, 16'h0100, 32'h0, 4'b0000, 3'b000, 0, 0, 1'b0, 32'h1111_2222);
    chk("post_rst_rdy_lit", 32'(seen_rdy), 32'd3);
    chk("post_rst_prdata_lit", seen_prdata, 32'h1111_2222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
